// File: rtl/zle_xc_dec_if.sv
// zle_xc_dec_if: token-in / word-out stream handshake bundle for the ZLE expander.
interface zle_xc_dec_if #(parameter int W = 8);
   logic         i_v, i_b, i_z, i_e;
   logic [W-1:0] i_d;
   logic         o_v, o_b, o_e;
   logic [W-1:0] o_d;
   modport slave(input i_v, i_d, i_z, i_e, o_b, output i_b, o_v, o_d, o_e);
   modport master(output i_v, i_d, i_z, i_e, o_b, input i_b, o_v, o_d, o_e);
endinterface

// File: rtl/zle_xc_dec.sv
// zle_xc_dec: expands literal / zero-run / end-of-stream tokens back into a word stream.
module zle_xc_dec #(
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic        clock,
   input  logic        reset,
   zle_xc_dec_if.slave s,
   output logic [1:0]  state
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EOSP = 2'd2} state_t;
   state_t          st, st_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            o_v_n, o_e_n, out_free, idle, in_fire;
   logic [W-1:0]    o_d_n;
   assign out_free = ~s.o_v | ~s.o_b;
   // EOSP is unreachable and decodes like IDLE
   assign idle     = st != RUN;
   assign s.i_b    = ~(idle & out_free);
   assign in_fire  = s.i_v & ~s.i_b;
   assign state    = st;
   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      o_v_n = s.o_v & s.o_b;
      o_d_n = s.o_d;
      o_e_n = s.o_e;
      if (idle) begin
         st_n = IDLE;
         if (in_fire) begin
            o_v_n = 1'b1;
            o_d_n = (s.i_e | s.i_z) ? '0 : s.i_d;
            o_e_n = s.i_e;
            if (!s.i_e && s.i_z && s.i_d[CW-1:0] != '0) begin
               cnt_n = s.i_d[CW-1:0];
               st_n  = RUN;
            end
         end
      end else if (out_free) begin
         o_v_n = 1'b1;
         o_d_n = '0;
         o_e_n = 1'b0;
         cnt_n = cnt - CW'(1);
         st_n  = (cnt == CW'(1)) ? IDLE : RUN;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st    <= IDLE;
         cnt   <= '0;
         s.o_v <= 1'b0;
         s.o_d <= '0;
         s.o_e <= 1'b0;
      end else begin
         st    <= st_n;
         cnt   <= cnt_n;
         s.o_v <= o_v_n;
         s.o_d <= o_d_n;
         s.o_e <= o_e_n;
      end
   end
endmodule

// File: tb/tb_zle_xc_dec.sv
// tb_zle_xc_dec: directed scenario tasks for the ZLE expander with an output-transfer monitor.
module tb_zle_xc_dec;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] state;
   int         tests = 0, fails = 0, cyc = 0;
   logic [7:0] qd[$];
   logic       qe[$];
   int         qc[$];
   zle_xc_dec_if #(.W(8)) iface();
   zle_xc_dec #(.W(8), .CW(8)) dut(.clock(clock), .reset(reset), .s(iface.slave), .state(state));
   always #5 clock = ~clock;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset && iface.o_v && !iface.o_b) begin
         qd.push_back(iface.o_d);
         qe.push_back(iface.o_e);
         qc.push_back(cyc);
      end
   end
   task automatic send(input logic [7:0] d, input logic z, input logic e, output int stalls);
      stalls = 0;
      iface.i_v = 1'b1; iface.i_d = d; iface.i_z = z; iface.i_e = e;
      while (iface.i_b && stalls < 1000) begin
         @(negedge clock);
         stalls++;
      end
      if (stalls >= 1000) begin
         tests++; fails++;
         $display("FAIL send_timeout: i_b stuck at %0b, required 0", iface.i_b);
      end
      @(negedge clock);
      iface.i_v = 1'b0;
   endtask
   task automatic clear_q();
      qd.delete(); qe.delete(); qc.delete();
   endtask
   task automatic test_reset();
      iface.i_v = 0; iface.i_d = 0; iface.i_z = 0; iface.i_e = 0; iface.o_b = 0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      tests++; if (iface.o_v !== 1'b0) begin fails++; $display("FAIL reset_o_v: got %0b want 0", iface.o_v); end
      tests++; if (iface.o_d !== 8'h00) begin fails++; $display("FAIL reset_o_d: got %h want 00", iface.o_d); end
      tests++; if (iface.o_e !== 1'b0) begin fails++; $display("FAIL reset_o_e: got %0b want 0", iface.o_e); end
      tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
      tests++; if (iface.i_b !== 1'b0) begin fails++; $display("FAIL reset_i_b: got %0b want 0", iface.i_b); end
      reset = 1'b1;
      @(negedge clock);
   endtask
   task automatic test_literals();
      logic [7:0] lit [3] = '{8'h12, 8'h34, 8'h56};
      int st;
      clear_q();
      for (int i = 0; i < 3; i++) begin
         send(lit[i], 1'b0, 1'b0, st);
         tests++; if (st != 0) begin fails++; $display("FAIL lit_i_b: stalls %0d want 0", st); end
         tests++; if (iface.o_v !== 1'b1 || iface.o_d !== lit[i]) begin
            fails++; $display("FAIL lit_out%0d: o_v=%0b o_d=%h want 1 %h", i, iface.o_v, iface.o_d, lit[i]);
         end
      end
      @(negedge clock);
      tests++; if (iface.o_v !== 1'b0) begin fails++; $display("FAIL lit_idle_o_v: got %0b want 0", iface.o_v); end
      tests++; if (qd.size() != 3 || qc[2] - qc[0] != 2) begin fails++; $display("FAIL lit_count: got %0d words want 3 consecutive", qd.size()); end
   endtask
   task automatic test_run_then_literal();
      logic [7:0] exp [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA};
      int st;
      clear_q();
      send(8'd3, 1'b1, 1'b0, st);
      tests++; if (state !== 2'd1) begin fails++; $display("FAIL run3_state: got %0d want 1", state); end
      send(8'hAA, 1'b0, 1'b0, st);
      tests++; if (st != 3) begin fails++; $display("FAIL run3_stalls: got %0d want 3", st); end
      tests++; if (state !== 2'd0) begin fails++; $display("FAIL run3_state_end: got %0d want 0", state); end
      repeat (2) @(negedge clock);
      tests++;
      if (qd.size() != 5) begin fails++; $display("FAIL run3_count: got %0d want 5", qd.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            tests++; if (qd[i] !== exp[i] || qe[i] !== 1'b0) begin fails++; $display("FAIL run3_word%0d: got %h/%0b want %h/0", i, qd[i], qe[i], exp[i]); end
         end
         tests++; if (qc[4] - qc[0] != 4) begin fails++; $display("FAIL run3_gap: span %0d want 4", qc[4] - qc[0]); end
      end
   endtask
   task automatic test_back_to_back();
      int st, bad = 0;
      clear_q();
      send(8'd0, 1'b1, 1'b0, st);
      send(8'd255, 1'b1, 1'b0, st);
      send(8'h3C, 1'b0, 1'b0, st);
      repeat (3) @(negedge clock);
      tests++;
      if (qd.size() != 258) begin fails++; $display("FAIL b2b_count: got %0d want 258", qd.size()); end
      else begin
         for (int i = 0; i < 257; i++) if (qd[i] !== 8'h00) bad++;
         tests++; if (bad != 0) begin fails++; $display("FAIL b2b_zeros: %0d nonzero words want 0", bad); end
         tests++; if (qd[257] !== 8'h3C) begin fails++; $display("FAIL b2b_lit: got %h want 3c", qd[257]); end
         tests++; if (qc[257] - qc[0] != 257) begin fails++; $display("FAIL b2b_gap: span %0d want 257", qc[257] - qc[0]); end
      end
   endtask
   task automatic test_backpressure();
      logic pat [10] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
      logic       hv;
      logic [7:0] pd;
      int st;
      clear_q();
      iface.o_b = 1'b0;
      send(8'd2, 1'b1, 1'b0, st);
      for (int k = 0; k < 10; k++) begin
         iface.o_b = pat[k];
         hv = iface.o_v & iface.o_b;
         pd = iface.o_d;
         @(negedge clock);
         if (hv) begin
            tests++; if (iface.o_v !== 1'b1 || iface.o_d !== pd) begin fails++; $display("FAIL bp_hold%0d: o_v=%0b o_d=%h want 1 %h", k, iface.o_v, iface.o_d, pd); end
         end
      end
      iface.o_b = 1'b0;
      tests++; if (qd.size() != 3) begin fails++; $display("FAIL bp_count: got %0d want 3", qd.size()); end
      tests++; if (qd.size() == 3 && (qd[0] | qd[1] | qd[2]) !== 8'h00) begin fails++; $display("FAIL bp_data: nonzero word in run"); end
   endtask
   task automatic test_eos();
      int st;
      clear_q();
      send(8'h07, 1'b0, 1'b0, st);
      send(8'h05, 1'b1, 1'b1, st);
      repeat (3) @(negedge clock);
      tests++;
      if (qd.size() != 2) begin fails++; $display("FAIL eos_count: got %0d want 2", qd.size()); end
      else begin
         tests++; if (qd[0] !== 8'h07 || qe[0] !== 1'b0) begin fails++; $display("FAIL eos_lit: got %h/%0b want 07/0", qd[0], qe[0]); end
         tests++; if (qd[1] !== 8'h00 || qe[1] !== 1'b1) begin fails++; $display("FAIL eos_mark: got %h/%0b want 00/1", qd[1], qe[1]); end
      end
      tests++; if (state !== 2'd0) begin fails++; $display("FAIL eos_state: got %0d want 0", state); end
   endtask
   task automatic test_reset_mid_run();
      int st, t = 0;
      clear_q();
      send(8'd10, 1'b1, 1'b0, st);
      while (qd.size() < 4 && t < 50) begin @(negedge clock); t++; end
      tests++; if (qd.size() != 4) begin fails++; $display("FAIL rst_run_progress: got %0d words want 4", qd.size()); end
      #2 reset = 1'b0;
      #1;
      tests++; if (iface.o_v !== 1'b0) begin fails++; $display("FAIL rst_async_o_v: got %0b want 0", iface.o_v); end
      tests++; if (state !== 2'd0) begin fails++; $display("FAIL rst_async_state: got %0d want 0", state); end
      @(negedge clock);
      reset = 1'b1;
      clear_q();
      send(8'h99, 1'b0, 1'b0, st);
      repeat (4) @(negedge clock);
      tests++; if (qd.size() != 1) begin fails++; $display("FAIL rst_residual: got %0d words want 1", qd.size()); end
      tests++; if (qd.size() >= 1 && qd[0] !== 8'h99) begin fails++; $display("FAIL rst_lit: got %h want 99", qd[0]); end
   endtask
   initial begin
      @(negedge clock);
      test_reset();
      test_literals();
      test_run_then_literal();
      test_back_to_back();
      test_backpressure();
      test_eos();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
